// File: rtl/sms4_pkg.sv
// Shared SMS4 constants and types for the key-schedule blocks.
// Latency: n/a (constants, types and a combinational helper only).
// Backpressure: n/a.
package sms4_pkg;

    localparam int SMS4_BWIDTH = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    // CK(i): byte j (byte 0 = most significant) is ((4i+j)*7) mod 256.
    function automatic logic [31:0] ck_word(input logic [4:0] i);
        logic [31:0] w;
        logic [7:0]  b;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            b = {1'b0, i, 2'b00} + 8'(j);
            w[31-8*j -: 8] = b * 8'd7;
        end
        return w;
    endfunction

endpackage

// File: rtl/sms4_tprime.sv
// SMS4 key-schedule transform T'(x) = L'(tau(x)), L'(b) = b ^ rotl(b,13) ^ rotl(b,23).
// Latency: purely combinational.
// Backpressure: none (no state).
// Ports: x = 32-bit input word, y = transformed word.
module sms4_tprime
    import sms4_pkg::*;
(
    input  logic [31:0] x,
    output logic [31:0] y
);

    logic [31:0] b;

    assign b = {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    assign y = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};

endmodule

// File: rtl/sms4_rk_unroll.sv
// Reverse SMS4 key schedule: from K32..K35 streams rk31..rk0, one key per accepted handshake.
// Latency: first key valid one cycle after start; 32 keys in 32 cycles with rk_ready held high.
// Backpressure: rk_ready low holds all state, rk_out/rk_idx stay stable until accepted.
// Ports: clk/rst (sync, active-high); start+kin load {K32,K33,K34,K35};
//        rk_out/rk_idx/rk_valid/rk_ready key stream; busy while running; done pulse after rk0.
// Optional: SMS4_MK_RECOVER_EN adds mk_out/mk_valid, the master key recovered at the end.
module sms4_rk_unroll
    import sms4_pkg::*;
#(
    parameter int BWIDTH = SMS4_BWIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [0:4*BWIDTH-1]   kin,
    output logic [0:BWIDTH-1]     rk_out,
    output logic [4:0]            rk_idx,
    output logic                  rk_valid,
    input  logic                  rk_ready,
    output logic                  busy,
    output logic                  done
`ifdef SMS4_MK_RECOVER_EN
    ,
    output logic [0:4*BWIDTH-1]   mk_out,
    output logic                  mk_valid
`endif
);

    state_t              state_q;
    logic [BWIDTH-1:0]   a_q, b_q, c_q, d_q;   // K(i+1), K(i+2), K(i+3), K(i+4)
    logic [4:0]          cnt_q;                // i
    logic [BWIDTH-1:0]   tp_in, tp_out, k_new;
    logic                hs;

    assign hs = rk_valid & rk_ready;

    // CK comes straight from the round index rather than a stored table.
    assign tp_in = a_q ^ b_q ^ c_q ^ ck_word(cnt_q);
    assign k_new = d_q ^ tp_out;

    sms4_tprime u_tprime (
        .x (tp_in),
        .y (tp_out)
    );

    assign rk_out = d_q;
    assign rk_idx = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        {a_q, b_q, c_q, d_q} <= kin;
                        cnt_q    <= 5'd31;
                        state_q  <= ST_RUN;
                        rk_valid <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (hs) begin
                        {a_q, b_q, c_q, d_q} <= {k_new, a_q, b_q, c_q};
                        cnt_q <= cnt_q - 5'd1;
                        if (cnt_q == 5'd0) begin
                            state_q  <= ST_IDLE;
                            rk_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef SMS4_MK_RECOVER_EN
    // On the rk0 handshake the new word is K0 and A..C hold K1..K3.
    always_ff @(posedge clk) begin
        if (rst) begin
            mk_out   <= '0;
            mk_valid <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            mk_valid <= 1'b0;
        end else if (state_q == ST_RUN && hs && cnt_q == 5'd0) begin
            mk_out   <= {k_new, a_q, b_q, c_q} ^ FK;
            mk_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sms4_rk_unroll.sv
// Self-checking bench for sms4_rk_unroll: standard vector, backpressure, start-in-run,
// mid-run reset and back-to-back start, with a queue of expected keys.
// Expected keys come from an independent forward key expansion in the bench.
module tb_sms4_rk_unroll;

    logic          clk;
    logic          rst;
    logic          start;
    logic [0:127]  kin;
    logic [0:31]   rk_out;
    logic [4:0]    rk_idx;
    logic          rk_valid;
    logic          rk_ready;
    logic          busy;
    logic          done;
`ifdef SMS4_MK_RECOVER_EN
    logic [0:127]  mk_out;
    logic          mk_valid;
`endif

    sms4_rk_unroll dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .kin      (kin),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .busy     (busy),
        .done     (done)
`ifdef SMS4_MK_RECOVER_EN
        ,
        .mk_out   (mk_out),
        .mk_valid (mk_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] TB_SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };
    localparam logic [31:0]  TB_FK [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
    localparam logic [127:0] TB_MK = 128'h0123456789ABCDEFFEDCBA9876543210;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] key;
    } exp_t;

    exp_t          sb_q[$];
    logic [31:0]   rk_m [32];
    logic [127:0]  std_kin;
    logic [127:0]  alt_kin;
    logic [31:0]   last_key;
    logic [31:0]   first_key;
    int            n_pass  = 0;
    int            n_total = 0;
    int            hs_cnt  = 0;
    int            ncyc    = 0;

    function automatic logic [31:0] m_tprime(input logic [31:0] x);
        logic [31:0] b;
        b = {TB_SBOX[x[31:24]], TB_SBOX[x[23:16]], TB_SBOX[x[15:8]], TB_SBOX[x[7:0]]};
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

    function automatic logic [31:0] m_ck(input int i);
        logic [31:0] w;
        int          v;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            v = ((4 * i + j) * 7) % 256;
            w = {w[23:0], v[7:0]};
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic push_exp();
        for (int i = 31; i >= 0; i--) sb_q.push_back({5'(i), rk_m[i]});
    endtask

    // One clock: score the output at the falling edge, then step past the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (rk_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 128'(rk_valid), 128'd0);
            end else begin
                check("rk_idx", 128'(rk_idx), 128'(sb_q[0].idx));
                check("rk_out", 128'(rk_out), 128'(sb_q[0].key));
                if (rk_ready) begin
                    hs_cnt++;
                    if (sb_q[0].idx == 5'd31) first_key = rk_out;
                    if (sb_q[0].idx == 5'd0)  last_key  = rk_out;
                    void'(sb_q.pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready high; mode 1: random ready plus a start pulse at idx 20; mode 2: reset at idx 15.
    task automatic drain(input int mode);
        bit pulsed  = 0;
        bit aborted = 0;
        ncyc = 0;
        for (int c = 0; c < 400 && sb_q.size() > 0; c++) begin
            start    = 1'b0;
            rk_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 1 && !pulsed && sb_q[0].idx == 5'd20) begin
                start  = 1'b1;
                kin    = alt_kin;
                pulsed = 1;
            end
            if (mode == 2 && sb_q[0].idx == 5'd15) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
                sb_q.delete();
                aborted = 1;
                break;
            end
            cycle();
            ncyc++;
        end
        start = 1'b0;
        kin   = std_kin;
        if (!aborted && sb_q.size() != 0) check("drain_timeout", 128'(sb_q.size()), 128'd0);
    endtask

    task automatic check_done_cycle(input string tag);
        check({tag, "_done"},     128'(done),     128'd1);
        check({tag, "_rk_valid"}, 128'(rk_valid), 128'd0);
        check({tag, "_busy"},     128'(busy),     128'd0);
`ifdef SMS4_MK_RECOVER_EN
        check({tag, "_mk_out"},   128'(mk_out),   TB_MK);
        check({tag, "_mk_valid"}, 128'(mk_valid), 128'd1);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] kk [36];
        for (int j = 0; j < 4; j++) kk[j] = TB_MK[127-32*j -: 32] ^ TB_FK[j];
        for (int i = 0; i < 32; i++) begin
            kk[i+4] = kk[i] ^ m_tprime(kk[i+1] ^ kk[i+2] ^ kk[i+3] ^ m_ck(i));
            rk_m[i] = kk[i+4];
        end
        std_kin = {rk_m[28], rk_m[29], rk_m[30], rk_m[31]};
        alt_kin = {$urandom, $urandom, $urandom, $urandom};

        rst = 1'b1; start = 1'b0; rk_ready = 1'b0; kin = std_kin;
        cycle();
        cycle();
        check("rst_rk_valid", 128'(rk_valid), 128'd0);
        check("rst_busy",     128'(busy),     128'd0);
        check("rst_done",     128'(done),     128'd0);
        check("rst_rk_out",   128'(rk_out),   128'd0);
        check("rst_rk_idx",   128'(rk_idx),   128'd0);
`ifdef SMS4_MK_RECOVER_EN
        check("rst_mk_out",   128'(mk_out),   128'd0);
        check("rst_mk_valid", 128'(mk_valid), 128'd0);
`endif
        rst = 1'b0;
        cycle();

        // Standard vector, ready held high.
        rk_ready = 1'b1;
        start = 1'b1;
        kin = std_kin;
        push_exp();
        cycle();
        start = 1'b0;
        check("std_busy_rise", 128'(busy),   128'd1);
        check("std_first_idx", 128'(rk_idx), 128'd31);
        hs_cnt = 0;
        drain(0);
        check("std_cycles",    128'(ncyc),      128'd32);
        check("std_handshakes", 128'(hs_cnt),   128'd32);
        check("std_rk31",      128'(first_key), 128'h9124A012);
        check("std_rk0",       128'(last_key),  128'hF12186F9);
        check_done_cycle("std");

        // Back-to-back start in the done cycle, then backpressure with an ignored start at idx 20.
        rk_ready = 1'b0;
        start = 1'b1;
        push_exp();
        cycle();
        start = 1'b0;
        check("b2b_rk_valid", 128'(rk_valid), 128'd1);
        check("b2b_rk_idx",   128'(rk_idx),   128'd31);
        check("b2b_busy",     128'(busy),     128'd1);
        check("b2b_done_low", 128'(done),     128'd0);
`ifdef SMS4_MK_RECOVER_EN
        check("b2b_mk_valid_clr", 128'(mk_valid), 128'd0);
`endif
        hs_cnt = 0;
        last_key = '0;
        drain(1);
        check("bp_handshakes", 128'(hs_cnt),   128'd32);
        check("bp_rk0",        128'(last_key), 128'hF12186F9);
        check_done_cycle("bp");
        rk_ready = 1'b1;
        cycle();
        check("bp_done_pulse", 128'(done), 128'd0);

        // Reset in the middle of a run.
        start = 1'b1;
        push_exp();
        cycle();
        start = 1'b0;
        drain(2);
        check("mrst_rk_valid", 128'(rk_valid), 128'd0);
        check("mrst_busy",     128'(busy),     128'd0);
        check("mrst_rk_out",   128'(rk_out),   128'd0);
        check("mrst_rk_idx",   128'(rk_idx),   128'd0);
        check("mrst_done",     128'(done),     128'd0);
`ifdef SMS4_MK_RECOVER_EN
        check("mrst_mk_valid", 128'(mk_valid), 128'd0);
`endif
        cycle();
        cycle();
        check("mrst_idle_valid", 128'(rk_valid), 128'd0);

        // Fresh start after the abort.
        start = 1'b1;
        push_exp();
        cycle();
        start = 1'b0;
        check("restart_idx", 128'(rk_idx), 128'd31);
        hs_cnt = 0;
        drain(0);
        check("restart_handshakes", 128'(hs_cnt), 128'd32);
        check_done_cycle("restart");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
